// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
//   - md_op encodings (MD_MULT .. MD_MTLO; 6/7 are reserved)
//   - default busy-cycle counts and timer width
//   - FSM state encoding
//   - md_compute(): full 64-bit arithmetic result for ops 0..3
// Used by md_if, md_busy_timer and md_ctrl. Optional flush support is
// controlled by the MD_FLUSH_EN macro (see md_if / md_ctrl).
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Returns {write_valid, hi, lo}. write_valid is 0 for a zero divisor
  // (hi/lo must then stay untouched) and for non-arithmetic ops.
  function automatic logic [64:0] md_compute(input logic [2:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [32:0] sa, sb, sq, sr;
    logic [63:0]        prod;
    logic [64:0]        res;
    sa   = '0;
    sb   = '0;
    sq   = '0;
    sr   = '0;
    prod = '0;
    res  = '0;
    case (op)
      // Low 64 bits of the sign-extended product equal the signed product.
      MD_MULT: begin
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res  = {1'b1, prod};
      end
      MD_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        res  = {1'b1, prod};
      end
      // 33-bit signed divide so 0x80000000 / -1 yields +2^31 without
      // overflow; its low 32 bits give lo=0x80000000, hi=0.
      MD_DIV: begin
        if (b != 32'd0) begin
          sa  = {a[31], a};
          sb  = {b[31], b};
          sq  = sa / sb;
          sr  = sa % sb;
          res = {1'b1, sr[31:0], sq[31:0]};
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          res = {1'b1, a % b, a / b};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/md_if.sv
// md_if: EX-stage <-> md_ctrl bus.
//   start  : one-cycle issue pulse carrying md_op/a/b. There is no ready
//            signal: an issue is accepted only when busy is low at that
//            edge; a start while busy is dropped. busy therefore acts as
//            the inverse of ready for the hazard unit.
//   md_op  : operation code (see md_pkg)
//   a, b   : rs / rt operands
//   busy   : an arithmetic op is in flight
//   hi, lo : architectural HI/LO registers
//   flush  : only with MD_FLUSH_EN; aborts the in-flight op
// Modports: master = EX stage / bench, slave = md_ctrl.
interface md_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MD_FLUSH_EN
  logic        flush;

  modport master (output start, md_op, a, b, flush, input busy, hi, lo);
  modport slave  (input start, md_op, a, b, flush, output busy, hi, lo);
`else
  modport master (output start, md_op, a, b, input busy, hi, lo);
  modport slave  (input start, md_op, a, b, output busy, hi, lo);
`endif
endinterface

// File: rtl/md_busy_timer.sv
// md_busy_timer: loadable down-counter that times an md operation.
// Ports:
//   clk        in  clock, rising edge
//   clear_i    in  synchronous clear (reset or flush), wins over load
//   load_i     in  load strobe
//   load_val_i in  busy-cycle count N to load
//   busy_o     out high for N cycles after the load edge
//   done_o     out high during the final busy cycle
module md_busy_timer
  import md_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         busy_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer owning HI/LO.
// The 64-bit result is computed at issue and parked in pend_hi/pend_lo;
// md_busy_timer models the latency, and hi/lo are written in one step at
// completion. mthi/mtlo write immediately when idle.
// Ports:
//   clk         in  clock, rising edge
//   reset       in  synchronous, active-high
//   bus         md_if.slave (start, md_op, a, b, busy, hi, lo[, flush])
//   dbg_state_o out current FSM state
// Macro MD_FLUSH_EN: enables the flush input, which aborts an in-flight
// op (priority: reset > flush > completion/start).
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  md_if.slave       bus,
  output md_state_e dbg_state_o
);

  md_state_e   state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_ok_q, pend_ok_d;
  logic        flush_w, issue_md, issue_mt, complete;
  logic        timer_busy, timer_done;
  logic [64:0] result;
  logic [CNT_W-1:0] load_val;

`ifdef MD_FLUSH_EN
  assign flush_w = bus.flush;
`else
  assign flush_w = 1'b0;
`endif

  assign result   = md_compute(bus.md_op, bus.a, bus.b);
  assign issue_md = bus.start && (state_q == ST_IDLE) && !flush_w &&
                    (bus.md_op <= MD_DIVU);
  assign issue_mt = bus.start && (state_q == ST_IDLE) && !flush_w &&
                    ((bus.md_op == MD_MTHI) || (bus.md_op == MD_MTLO));
  assign complete = (state_q == ST_RUN) && timer_done && !flush_w;
  assign load_val = (bus.md_op[1]) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  md_busy_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .clear_i    (reset || flush_w),
    .load_i     (issue_md),
    .load_val_i (load_val),
    .busy_o     (timer_busy),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_md) begin
          state_d = ST_RUN;
          {pend_ok_d, pend_hi_d, pend_lo_d} = result;
        end else if (issue_mt) begin
          if (bus.md_op == MD_MTHI) hi_d = bus.a;
          else                      lo_d = bus.a;
        end
      end
      ST_RUN: begin
        if (timer_done) state_d = ST_IDLE;
        // Zero-divisor ops complete without touching hi/lo.
        if (complete && pend_ok_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_w) begin
      state_d   = ST_IDLE;
      pend_ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
    end
  end

  assign bus.busy    = timer_busy;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: self-checking bench for md_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
// Expected hi/lo come from a behavioural model using 64-bit integer
// arithmetic; expected values are queued in exp_q and popped at completion.
// Define MD_FLUSH_EN to also exercise the flush feature.
module tb_md_ctrl;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic      clk = 1'b0;
  logic      reset;
  md_state_e dbg_state;
  md_if      u_if ();

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (u_if.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    if (u_if.start && u_if.busy)
      $display("warning: start ignored while busy (md_op=%0d) at %0t", u_if.md_op, $time);
  end

  // Reference model: updates exp_hi/exp_lo from the architectural rules
  // and queues the resulting {hi, lo}.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    case (op)
      3'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd1: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
      3'd3: if (b != 0) begin p = ua / ub; exp_lo = p[31:0]; p = ua % ub; exp_hi = p[31:0]; end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
    exp_q.push_back(exp_hi);
    exp_q.push_back(exp_lo);
  endtask

  // Issue one start pulse; returns #1 after the issuing edge.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    u_if.start = 1'b1;
    u_if.md_op = op;
    u_if.a     = a;
    u_if.b     = b;
    @(posedge clk); #1;
    u_if.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    total++;
    if (u_if.busy !== 1'b0 || u_if.hi !== 32'd0 || u_if.lo !== 32'd0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset: busy=%b hi=%h lo=%h state=%0d, want busy=0 hi=0 lo=0 idle",
               u_if.busy, u_if.hi, u_if.lo, dbg_state);
    end
  endtask

  task automatic test_mult();
    logic [2:0]  op;
    logic [31:0] a, b, ph, pl, eh, el;
    for (int v = 0; v < 8; v++) begin
      if (v == 0)      begin op = 3'd0; a = 32'd5;        b = 32'hFFFFFFFD; end
      else if (v == 1) begin op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
      else             begin op = 3'($urandom_range(0, 1)); a = $urandom; b = $urandom; end
      ph = exp_hi; pl = exp_lo;
      ref_op(op, a, b);
      drive(op, a, b);
      for (int i = 1; i <= MC; i++) begin
        total++;
        if (u_if.busy !== 1'b1 || u_if.hi !== ph || u_if.lo !== pl || dbg_state !== ST_RUN) begin
          bad++;
          $display("FAIL mult_busy v%0d cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                   v, i, u_if.busy, u_if.hi, u_if.lo, ph, pl);
        end
        @(posedge clk); #1;
      end
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      total++;
      if (u_if.busy !== 1'b0 || u_if.hi !== eh || u_if.lo !== el) begin
        bad++;
        $display("FAIL mult_result v%0d op%0d a=%h b=%h: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                 v, op, a, b, u_if.busy, u_if.hi, u_if.lo, eh, el);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  op;
    logic [31:0] a, b, ph, pl, eh, el;
    for (int v = 0; v < 11; v++) begin
      case (v)
        0: begin op = 3'd3; a = 32'd7;        b = 32'd2;        end
        1: begin op = 3'd2; a = 32'hFFFFFFF9; b = 32'd2;        end
        2: begin op = 3'd2; a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: begin op = 3'd2; a = 32'h12345678; b = 32'd0;        end
        4: begin op = 3'd3; a = 32'hCAFEF00D; b = 32'd0;        end
        default: begin
          op = 3'($urandom_range(2, 3));
          a  = $urandom;
          b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
        end
      endcase
      ph = exp_hi; pl = exp_lo;
      ref_op(op, a, b);
      drive(op, a, b);
      for (int i = 1; i <= DC; i++) begin
        total++;
        if (u_if.busy !== 1'b1 || u_if.hi !== ph || u_if.lo !== pl) begin
          bad++;
          $display("FAIL div_busy v%0d cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                   v, i, u_if.busy, u_if.hi, u_if.lo, ph, pl);
        end
        @(posedge clk); #1;
      end
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      total++;
      if (u_if.busy !== 1'b0 || u_if.hi !== eh || u_if.lo !== el) begin
        bad++;
        $display("FAIL div_result v%0d op%0d a=%h b=%h: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                 v, op, a, b, u_if.busy, u_if.hi, u_if.lo, eh, el);
      end
    end
  endtask

  task automatic test_mt();
    logic [2:0]  op;
    logic [31:0] a, eh, el;
    for (int v = 0; v < 8; v++) begin
      if (v == 0) begin op = 3'd4; a = 32'h1234; end
      else begin op = 3'($urandom_range(4, 7)); a = $urandom; end
      ref_op(op, a, $urandom);
      drive(op, a, $urandom);
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (u_if.busy !== 1'b0 || u_if.hi !== eh || u_if.lo !== el) begin
          bad++;
          $display("FAIL mt v%0d op%0d cyc%0d: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                   v, op, i, u_if.busy, u_if.hi, u_if.lo, eh, el);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] ph, pl, eh, el;
    ph = exp_hi; pl = exp_lo;
    ref_op(3'd2, 32'd100, 32'd7);
    drive(3'd2, 32'd100, 32'd7);
    for (int i = 1; i <= DC; i++) begin
      total++;
      if (u_if.busy !== 1'b1 || u_if.hi !== ph || u_if.lo !== pl) begin
        bad++;
        $display("FAIL ignore_busy cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                 i, u_if.busy, u_if.hi, u_if.lo, ph, pl);
      end
      if (i == 3) begin
        u_if.start = 1'b1; u_if.md_op = 3'd0; u_if.a = 32'd3; u_if.b = 32'd4;
      end
      @(posedge clk); #1;
      u_if.start = 1'b0;
    end
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    for (int i = 0; i < MC + 2; i++) begin
      total++;
      if (u_if.busy !== 1'b0 || u_if.hi !== eh || u_if.lo !== el) begin
        bad++;
        $display("FAIL ignore_result cyc%0d: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                 i, u_if.busy, u_if.hi, u_if.lo, eh, el);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    ref_op(3'd4, 32'hDEAD, 32'd0); drive(3'd4, 32'hDEAD, 32'd0);
    ref_op(3'd5, 32'hBEEF, 32'd0); drive(3'd5, 32'hBEEF, 32'd0);
    exp_q.delete();
    drive(3'd0, 32'd7, 32'd9);
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (u_if.busy !== 1'b1 || u_if.hi !== 32'hDEAD || u_if.lo !== 32'hBEEF) begin
        bad++;
        $display("FAIL rstmid_busy cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=0000dead lo=0000beef",
                 i, u_if.busy, u_if.hi, u_if.lo);
      end
      if (i == 3) reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
    exp_hi = '0;
    exp_lo = '0;
    for (int i = 0; i < MC + 2; i++) begin
      total++;
      if (u_if.busy !== 1'b0 || u_if.hi !== exp_hi || u_if.lo !== exp_lo || dbg_state !== ST_IDLE) begin
        bad++;
        $display("FAIL rstmid_after cyc%0d: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0",
                 i, u_if.busy, u_if.hi, u_if.lo);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef MD_FLUSH_EN
  task automatic test_flush();
    ref_op(3'd4, 32'hAAAA, 32'd0); drive(3'd4, 32'hAAAA, 32'd0);
    ref_op(3'd5, 32'h5555, 32'd0); drive(3'd5, 32'h5555, 32'd0);
    exp_q.delete();
    drive(3'd0, 32'd2, 32'd3);
    for (int i = 1; i <= MC; i++) begin
      total++;
      if (u_if.busy !== 1'b1) begin
        bad++;
        $display("FAIL flush_busy cyc%0d: busy=%b, want 1", i, u_if.busy);
      end
      if (i == MC) u_if.flush = 1'b1;
      @(posedge clk); #1;
      u_if.flush = 1'b0;
    end
    // Same-edge flush and mthi: the write must be dropped.
    u_if.flush = 1'b1;
    drive(3'd4, 32'h77, 32'd0);
    u_if.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (u_if.busy !== 1'b0 || u_if.hi !== 32'hAAAA || u_if.lo !== 32'h5555) begin
        bad++;
        $display("FAIL flush_after cyc%0d: busy=%b hi=%h lo=%h, want busy=0 hi=0000aaaa lo=00005555",
                 i, u_if.busy, u_if.hi, u_if.lo);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
    u_if.a     = '0;
    u_if.b     = '0;
`ifdef MD_FLUSH_EN
    u_if.flush = 1'b0;
`endif
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_ignore_start();
    test_reset_mid();
`ifdef MD_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
